// File: rtl/mem_arb_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and the byte-serial memory controller.
interface mem_arb_if #(
    parameter int ADDR_W = 32
);
    // Handshake: if_req/mm_req are levels held until the matching one-cycle ok pulse
    // (or until an IF flush); dn_req and dn_done are one-cycle pulses with no back-pressure.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_ok;
    logic [31:0]       if_data;

    logic              mm_req;
    logic [ADDR_W-1:0] mm_addr;
    logic              mm_wr;
    logic [1:0]        mm_len;
    logic [31:0]       mm_wdata;
    logic              mm_ok;
    logic [31:0]       mm_rdata;

    logic              dn_req;
    logic [ADDR_W-1:0] dn_addr;
    logic              dn_wr;
    logic [1:0]        dn_len;
    logic [31:0]       dn_wdata;
    logic              dn_done;
    logic [31:0]       dn_rdata;

    logic              busy;
    logic              owner;
    logic [1:0]        state_dbg;

    modport master (
        output if_req, if_addr, if_flush, mm_req, mm_addr, mm_wr, mm_len, mm_wdata,
               dn_done, dn_rdata,
        input  if_ok, if_data, mm_ok, mm_rdata, dn_req, dn_addr, dn_wr, dn_len, dn_wdata,
               busy, owner, state_dbg
    );

    modport slave (
        input  if_req, if_addr, if_flush, mm_req, mm_addr, mm_wr, mm_len, mm_wdata,
               dn_done, dn_rdata,
        output if_ok, if_data, mm_ok, mm_rdata, dn_req, dn_addr, dn_wr, dn_len, dn_wdata,
               busy, owner, state_dbg
    );
endinterface

// File: rtl/mem_arb.sv
// Arbiter sharing one memory controller port between instruction fetch and load/store,
// MEM-first with a streak bound so IF cannot starve.
module mem_arb #(
    parameter int ADDR_W     = 32,
    parameter int STREAK_MAX = 4,
    parameter int STREAK_W   = 3
) (
    input logic       clk,
    input logic       rst_n,
    mem_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_DN = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic                drop;

    logic                if_elig;
    logic                streak_full;
    logic                grant_mm;
    logic                grant_if;
    logic [ADDR_W-1:0]   grant_addr;
    logic [1:0]          grant_len;

    always_comb begin
        if_elig     = bus.if_req && !bus.if_flush;
        streak_full = (streak == STREAK_W'(STREAK_MAX));
        grant_mm    = 1'b0;
        grant_if    = 1'b0;
        if (state == IDLE) begin
            if (bus.mm_req && !(if_elig && streak_full)) begin
                grant_mm = 1'b1;
            end else if (if_elig) begin
                grant_if = 1'b1;
            end
        end
        grant_addr = grant_mm ? bus.mm_addr : bus.if_addr;
        // A 3-byte access is not supported downstream, so length 2 widens to a word.
        if (!grant_mm || bus.mm_len == 2'd2) begin
            grant_len = 2'd3;
        end else begin
            grant_len = bus.mm_len;
        end
    end

    // A flush in RESP must kill if_ok in the same cycle, so the pulse is decoded here.
    assign bus.if_ok     = (state == RESP) && !bus.owner && !drop && !bus.if_flush;
    assign bus.state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            streak       <= '0;
            drop         <= 1'b0;
            bus.mm_ok    <= 1'b0;
            bus.dn_req   <= 1'b0;
            bus.dn_wr    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.owner    <= 1'b0;
            bus.dn_addr  <= '0;
            bus.dn_len   <= 2'd0;
            bus.dn_wdata <= 32'd0;
            bus.if_data  <= 32'd0;
            bus.mm_rdata <= 32'd0;
        end else begin
            bus.dn_req <= 1'b0;
            bus.mm_ok  <= 1'b0;

            if (bus.if_flush && !bus.owner && (state == ISSUE || state == WAIT_DN)) begin
                drop <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (grant_mm || grant_if) begin
                        state        <= ISSUE;
                        bus.dn_req   <= 1'b1;
                        bus.busy     <= 1'b1;
                        bus.owner    <= grant_mm;
                        bus.dn_addr  <= grant_addr;
                        bus.dn_len   <= grant_len;
                        bus.dn_wr    <= grant_mm && bus.mm_wr;
                        bus.dn_wdata <= grant_mm ? bus.mm_wdata : 32'd0;
                        if (grant_mm && if_elig) begin
                            if (!streak_full) begin
                                streak <= streak + STREAK_W'(1);
                            end
                        end else begin
                            streak <= '0;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT_DN;
                end
                WAIT_DN: begin
                    if (bus.dn_done) begin
                        state <= RESP;
                        if (bus.owner) begin
                            bus.mm_ok    <= 1'b1;
                            bus.mm_rdata <= bus.dn_wr ? 32'd0 : bus.dn_rdata;
                        end else begin
                            bus.if_data <= bus.dn_rdata;
                        end
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    drop     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: scenario tasks against a reactive controller model and an expected-data queue.
module tb_mem_arb;

    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_arb_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arb #(.ADDR_W(ADDR_W), .STREAK_MAX(4), .STREAK_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [0:0]  grant_q[$];

    // Controller model knobs, written only by the main sequence
    int          ctl_k        = 1;
    bit          ctl_early    = 1'b0;
    bit          ctl_fixed_en = 1'b0;
    logic [31:0] ctl_fixed    = 32'd0;

    function automatic logic [31:0] rdata_model(input logic [ADDR_W-1:0] a);
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    // Controller: answers each dn_req with dn_done ctl_k cycles later; gives up if the arbiter resets
    initial begin
        bus.dn_done  = 1'b0;
        bus.dn_rdata = 32'd0;
        forever begin
            @(negedge clk);
            bus.dn_done = 1'b0;
            if (bus.dn_req) begin
                int  n;
                bit  abort;
                n     = 0;
                abort = 1'b0;
                bus.dn_done  = ctl_early;
                bus.dn_rdata = ctl_early ? 32'h0BAD0BAD : 32'd0;
                while (n < ctl_k && !abort) begin
                    @(negedge clk);
                    bus.dn_done = 1'b0;
                    if (!bus.busy) abort = 1'b1;
                    n++;
                end
                if (!abort) begin
                    bus.dn_done  = 1'b1;
                    bus.dn_rdata = ctl_fixed_en ? ctl_fixed : rdata_model(bus.dn_addr);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_dn_req(output int cyc);
        cyc = -1;
        for (int i = 0; i <= 40; i++) begin
            if (bus.dn_req) begin
                cyc = i;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_if_ok(output int cyc);
        cyc = -1;
        for (int i = 0; i <= 40; i++) begin
            if (bus.if_ok) begin
                cyc = i;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_mm_ok(output int cyc);
        cyc = -1;
        for (int i = 0; i <= 40; i++) begin
            if (bus.mm_ok) begin
                cyc = i;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.if_flush = 1'b0;
        bus.mm_req   = 1'b0;
        bus.mm_addr  = '0;
        bus.mm_wr    = 1'b0;
        bus.mm_len   = 2'd0;
        bus.mm_wdata = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.owner, bus.dn_req, bus.dn_wr, bus.if_ok, bus.mm_ok} !== 6'd0)
            begin errors++; $display("FAIL reset_ctrl: got %b want 000000",
                {bus.busy, bus.owner, bus.dn_req, bus.dn_wr, bus.if_ok, bus.mm_ok}); end
        checks++;
        if ({bus.dn_addr, bus.dn_len, bus.dn_wdata} !== '0)
            begin errors++; $display("FAIL reset_dn: got addr %h len %0d wdata %h want zeros",
                bus.dn_addr, bus.dn_len, bus.dn_wdata); end
        checks++;
        if ({bus.if_data, bus.mm_rdata, bus.state_dbg} !== '0)
            begin errors++; $display("FAIL reset_data: got if_data %h mm_rdata %h state %0d want zeros",
                bus.if_data, bus.mm_rdata, bus.state_dbg); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_if_fetch();
        int cyc;
        logic [31:0] exp;
        ctl_k = 3; ctl_fixed_en = 1'b1; ctl_fixed = 32'h00112233;
        exp_q.push_back(32'h00112233);
        bus.if_req = 1'b1; bus.if_addr = 32'h1000;
        wait_dn_req(cyc);
        checks++;
        if (cyc !== 1) begin errors++; $display("FAIL fetch_dn_req_lat: got %0d want 1", cyc); end
        checks++;
        if ({bus.dn_addr, bus.dn_len, bus.dn_wr, bus.dn_wdata, bus.owner} !== {32'h1000, 2'd3, 1'b0, 32'd0, 1'b0})
            begin errors++; $display("FAIL fetch_dn_fields: got addr %h len %0d wr %b wdata %h owner %b",
                bus.dn_addr, bus.dn_len, bus.dn_wr, bus.dn_wdata, bus.owner); end
        wait_if_ok(cyc);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL fetch_ok_lat: got %0d want 4", cyc); end
        exp = exp_q.pop_front();
        checks++;
        if (bus.if_data !== exp) begin errors++; $display("FAIL fetch_data: got %h want %h", bus.if_data, exp); end
        bus.if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.if_ok} !== 2'b00)
            begin errors++; $display("FAIL fetch_idle: got busy %b if_ok %b want 0 0", bus.busy, bus.if_ok); end
    endtask

    task automatic test_mm_write();
        int cyc;
        logic [31:0] exp;
        ctl_k = 2; ctl_fixed_en = 1'b0;
        exp_q.push_back(32'd0);
        bus.mm_req = 1'b1; bus.mm_addr = 32'h30004; bus.mm_wr = 1'b1;
        bus.mm_len = 2'd0; bus.mm_wdata = 32'hAB;
        wait_dn_req(cyc);
        checks++;
        if ({bus.dn_addr, bus.dn_len, bus.dn_wr, bus.dn_wdata, bus.owner} !== {32'h30004, 2'd0, 1'b1, 32'hAB, 1'b1})
            begin errors++; $display("FAIL wr_dn_fields: got addr %h len %0d wr %b wdata %h owner %b",
                bus.dn_addr, bus.dn_len, bus.dn_wr, bus.dn_wdata, bus.owner); end
        wait_mm_ok(cyc);
        checks++;
        if (cyc !== 3) begin errors++; $display("FAIL wr_ok_lat: got %0d want 3", cyc); end
        exp = exp_q.pop_front();
        checks++;
        if ({bus.mm_rdata, bus.if_ok} !== {exp, 1'b0})
            begin errors++; $display("FAIL wr_rdata: got rdata %h if_ok %b want %h 0", bus.mm_rdata, bus.if_ok, exp); end
        bus.mm_req = 1'b0; bus.mm_wr = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_idle: got busy %b want 0", bus.busy); end
    endtask

    task automatic test_flush_wait();
        int cyc;
        int saw;
        ctl_k = 3; ctl_fixed_en = 1'b1; ctl_fixed = 32'h55555555;
        bus.if_req = 1'b1; bus.if_addr = 32'h1800;
        wait_dn_req(cyc);
        @(negedge clk);
        bus.if_flush = 1'b1; bus.if_req = 1'b0;
        @(negedge clk);
        bus.if_flush = 1'b0;
        saw = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.if_ok) saw++;
            @(negedge clk);
        end
        checks++;
        if (saw !== 0) begin errors++; $display("FAIL flush_wait_ok: got %0d if_ok pulses want 0", saw); end
        checks++;
        if ({bus.busy, bus.state_dbg} !== 3'd0)
            begin errors++; $display("FAIL flush_wait_idle: got busy %b state %0d want 0 0", bus.busy, bus.state_dbg); end
    endtask

    task automatic test_fetch_after_flush();
        int cyc;
        logic [31:0] exp;
        ctl_k = 2; ctl_fixed_en = 1'b0;
        exp_q.push_back(rdata_model(32'h2000));
        bus.if_req = 1'b1; bus.if_addr = 32'h2000;
        wait_dn_req(cyc);
        wait_if_ok(cyc);
        checks++;
        if (cyc !== 3) begin errors++; $display("FAIL refetch_ok_lat: got %0d want 3", cyc); end
        exp = exp_q.pop_front();
        checks++;
        if (bus.if_data !== exp) begin errors++; $display("FAIL refetch_data: got %h want %h", bus.if_data, exp); end
        bus.if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush_edges();
        int cyc;
        // flush coincident with dn_done
        ctl_k = 1; ctl_fixed_en = 1'b1; ctl_fixed = 32'h77777777;
        bus.if_req = 1'b1; bus.if_addr = 32'h2400;
        wait_dn_req(cyc);
        @(negedge clk);
        bus.if_flush = 1'b1; bus.if_req = 1'b0;
        @(negedge clk);
        bus.if_flush = 1'b0;
        checks++;
        if ({bus.if_ok, bus.busy} !== 2'b01)
            begin errors++; $display("FAIL flush_done_resp: got if_ok %b busy %b want 0 1", bus.if_ok, bus.busy); end
        @(negedge clk);
        // flush during the response cycle itself
        ctl_fixed = 32'h88888888;
        bus.if_req = 1'b1; bus.if_addr = 32'h2800;
        wait_dn_req(cyc);
        repeat (2) @(negedge clk);
        bus.if_flush = 1'b1; bus.if_req = 1'b0;
        #1;
        checks++;
        if ({bus.if_ok, bus.state_dbg} !== 3'b0_11)
            begin errors++; $display("FAIL flush_resp: got if_ok %b state %0d want 0 3", bus.if_ok, bus.state_dbg); end
        @(negedge clk);
        bus.if_flush = 1'b0;
        checks++;
        if ({bus.if_ok, bus.busy} !== 2'b00)
            begin errors++; $display("FAIL flush_resp_after: got if_ok %b busy %b want 0 0", bus.if_ok, bus.busy); end
    endtask

    task automatic test_streak();
        int cyc;
        logic [0:0] exp_own;
        logic [31:0] exp;
        ctl_k = 1; ctl_fixed_en = 1'b0;
        for (int g = 0; g < 10; g++) grant_q.push_back((g % 5) == 4 ? 1'b0 : 1'b1);
        exp_q.push_back(rdata_model(32'h4000));
        bus.if_req = 1'b1; bus.if_addr = 32'h4000;
        bus.mm_req = 1'b1; bus.mm_addr = 32'h5000; bus.mm_wr = 1'b0; bus.mm_len = 2'd3;
        for (int g = 0; g < 10; g++) begin
            wait_dn_req(cyc);
            checks++;
            if (cyc < 0) begin
                errors++; $display("FAIL streak_timeout: got no dn_req want grant %0d", g);
                break;
            end
            exp_own = grant_q.pop_front();
            checks++;
            if ({bus.owner, bus.dn_addr} !== {exp_own, (exp_own == 1'b1) ? 32'h5000 : 32'h4000})
                begin errors++; $display("FAIL streak_grant%0d: got owner %b addr %h want owner %b",
                    g, bus.owner, bus.dn_addr, exp_own); end
            if (g == 9) bus.mm_req = 1'b0;
            @(negedge clk);
        end
        wait_if_ok(cyc);
        exp = exp_q.pop_front();
        checks++;
        if (bus.if_data !== exp) begin errors++; $display("FAIL streak_if_data: got %h want %h", bus.if_data, exp); end
        bus.if_req = 1'b0;
        grant_q.delete();
        @(negedge clk);
    endtask

    task automatic test_len2_early();
        int cyc;
        logic [31:0] exp;
        ctl_k = 3; ctl_early = 1'b1; ctl_fixed_en = 1'b1; ctl_fixed = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        bus.mm_req = 1'b1; bus.mm_addr = 32'h600; bus.mm_wr = 1'b0; bus.mm_len = 2'd2;
        wait_dn_req(cyc);
        checks++;
        if ({bus.dn_len, bus.dn_wr} !== {2'd3, 1'b0})
            begin errors++; $display("FAIL len2_dn: got len %0d wr %b want 3 0", bus.dn_len, bus.dn_wr); end
        wait_mm_ok(cyc);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL len2_ok_lat: got %0d want 4", cyc); end
        exp = exp_q.pop_front();
        checks++;
        if (bus.mm_rdata !== exp) begin errors++; $display("FAIL len2_rdata: got %h want %h", bus.mm_rdata, exp); end
        bus.mm_req = 1'b0; ctl_early = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [31:0] exp;
        ctl_k = 6; ctl_fixed_en = 1'b0;
        bus.mm_req = 1'b1; bus.mm_addr = 32'h700; bus.mm_wr = 1'b0; bus.mm_len = 2'd3;
        wait_dn_req(cyc);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.owner, bus.dn_req, bus.dn_wr, bus.if_ok, bus.mm_ok, bus.dn_len, bus.state_dbg} !== '0)
            begin errors++; $display("FAIL rstmid_ctrl: got busy %b owner %b dn_req %b state %0d want zeros",
                bus.busy, bus.owner, bus.dn_req, bus.state_dbg); end
        checks++;
        if ({bus.dn_addr, bus.dn_wdata, bus.if_data, bus.mm_rdata} !== '0)
            begin errors++; $display("FAIL rstmid_data: got addr %h if_data %h mm_rdata %h want zeros",
                bus.dn_addr, bus.if_data, bus.mm_rdata); end
        rst_n = 1'b1;
        ctl_k = 1;
        exp_q.push_back(rdata_model(32'h700));
        @(negedge clk);
        checks++;
        if ({bus.dn_req, bus.owner, bus.dn_addr} !== {1'b1, 1'b1, 32'h700})
            begin errors++; $display("FAIL rstmid_regrant: got dn_req %b owner %b addr %h want 1 1 00000700",
                bus.dn_req, bus.owner, bus.dn_addr); end
        wait_mm_ok(cyc);
        exp = exp_q.pop_front();
        checks++;
        if (bus.mm_rdata !== exp) begin errors++; $display("FAIL rstmid_rdata: got %h want %h", bus.mm_rdata, exp); end
        bus.mm_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_if_fetch();
        test_mm_write();
        test_flush_wait();
        test_fetch_after_flush();
        test_flush_edges();
        test_streak();
        test_len2_early();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
